// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch front end for the 60-bit processor. Holds the program
//   counter, issues a one-cycle request to instruction memory, captures the
//   returned word and selects the next PC from the control unit's
//   branch/jump decision and the ALU zero flag.
//
// Optional feature macro: IFU_TIMEOUT_EN
//   When defined, a fetch that sees no imem_valid for TIMEOUT cycles in
//   S_WAIT sets the sticky fetch_err flag and is reissued to the same PC.
//   When undefined, S_WAIT waits indefinitely and fetch_err is tied to 0.
//
// Parameters
//   ADDR_W   : PC / instruction-memory word-address width (1..56)
//   RESET_PC : PC value loaded by reset
//   TIMEOUT  : S_WAIT cycles before a fetch is reissued (1..255)
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   stall                 : hold in S_FETCH without issuing a request
//   imem_req, imem_addr   : request pulse and registered word address
//   imem_rdata, imem_valid: returned instruction word and its valid strobe
//   instr, opcode         : registered instruction and its top 4 bits
//   instr_valid           : high while the instruction is being decoded
//   branch_en, jump_en    : control-unit decisions, sampled in S_DECODE
//   alu_zero              : ALU zero flag, sampled in S_DECODE
//   pc                    : address of the instruction in fetch/decode
//   fetch_err             : sticky fetch timeout flag
//
// State table
//   state    | meaning
//   S_FETCH  | idle with pc valid; issue request unless stalled
//   S_WAIT   | request outstanding; capture word on imem_valid
//   S_DECODE | instruction presented; pick next pc, return to S_FETCH

module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [59:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [59:0]       instr,
    output logic [3:0]        opcode,
    output logic              instr_valid,
    input  logic              branch_en,
    input  logic              jump_en,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    if (ADDR_W < 1 || ADDR_W > 56 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("instr_fetch_unit: ADDR_W or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              req_nxt;
    logic [59:0]       instr_nxt;

`ifdef IFU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt, cnt_nxt;
    logic       err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            instr     <= '0;
`ifdef IFU_TIMEOUT_EN
            cnt       <= '0;
            fetch_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            instr     <= instr_nxt;
`ifdef IFU_TIMEOUT_EN
            cnt       <= cnt_nxt;
            fetch_err <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        addr_nxt  = imem_addr;
        req_nxt   = 1'b0;
        instr_nxt = instr;
`ifdef IFU_TIMEOUT_EN
        cnt_nxt   = cnt;
        err_nxt   = fetch_err;
`endif
        case (state)
            S_FETCH: begin
                if (!stall) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                    state_nxt = S_WAIT;
`ifdef IFU_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            S_WAIT: begin
                // A response arriving on the last timeout cycle still wins.
                if (imem_valid) begin
                    instr_nxt = imem_rdata;
                    state_nxt = S_DECODE;
                end
`ifdef IFU_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
`endif
            end
            S_DECODE: begin
                state_nxt = S_FETCH;
                if (jump_en || (branch_en && alu_zero)) begin
                    pc_nxt = instr[ADDR_W-1:0];
                end else begin
                    pc_nxt = pc + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign instr_valid = (state == S_DECODE);
    assign opcode      = instr[59:56];

`ifndef IFU_TIMEOUT_EN
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int             AW  = 8;
    localparam logic [AW-1:0]  RPC = 8'h00;
    localparam int             TMO = 15;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [59:0]   imem_rdata;
    logic          imem_valid;
    logic [59:0]   instr;
    logic [3:0]    opcode;
    logic          instr_valid;
    logic          branch_en;
    logic          jump_en;
    logic          alu_zero;
    logic [AW-1:0] pc;
    logic          fetch_err;

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .branch_en  (branch_en),
        .jump_en    (jump_en),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {P_FETCH, P_REQ, P_WAIT, P_DEC} phase_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    bit            chk_en = 0;
    phase_t        phase  = P_FETCH;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] exp_addr;
    logic [59:0]   exp_instr;
    logic          exp_err;
    logic [AW-1:0] req_log[$];
    int            dec_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [59:0] rand60();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[59:0];
    endfunction

    // Every-cycle comparison against the transaction-level expectation.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("imem_req",    64'(imem_req),    64'(phase == P_REQ));
            check("instr_valid", 64'(instr_valid), 64'(phase == P_DEC));
            check("imem_addr",   64'(imem_addr),   64'(exp_addr));
            check("pc",          64'(pc),          64'(exp_pc));
            check("instr",       64'(instr),       64'(exp_instr));
            check("opcode",      64'(opcode),      64'(exp_instr[59:56]));
            check("fetch_err",   64'(fetch_err),   64'(exp_err));
            if (imem_req)    req_log.push_back(imem_addr);
            if (instr_valid) dec_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one whole instruction starting in a fetch cycle and ending in
    // the following fetch cycle; updates the expected pc from the rules.
    task automatic run_instr(input logic [59:0] data, input bit br, input bit jp,
                             input bit z, input int nwait, input int nstall);
        for (int i = 0; i < nstall; i++) begin
            phase      = P_FETCH;
            stall      = 1'b1;
            imem_valid = 1'b1;
            imem_rdata = rand60();
            step();
        end
        phase      = P_FETCH;
        stall      = 1'b0;
        imem_valid = 1'b0;
        step();
        phase    = P_REQ;
        exp_addr = exp_pc;
        for (int w = 0; w < nwait; w++) begin
            imem_valid = 1'b0;
            stall      = 1'($urandom % 2);
            step();
            phase = P_WAIT;
        end
        imem_valid = 1'b1;
        imem_rdata = data;
        stall      = 1'($urandom % 2);
        step();
        phase      = P_DEC;
        exp_instr  = data;
        imem_valid = 1'($urandom % 2);
        imem_rdata = rand60();
        branch_en  = br;
        jump_en    = jp;
        alu_zero   = z;
        step();
        phase = P_FETCH;
        if (jp || (br && z)) exp_pc = data[AW-1:0];
        else                 exp_pc = AW'((int'(exp_pc) + 1) % (1 << AW));
        imem_valid = 1'b0;
        branch_en  = 1'($urandom % 2);
        jump_en    = 1'($urandom % 2);
        alu_zero   = 1'($urandom % 2);
    endtask

    function automatic logic [59:0] mk(input logic [3:0] op, input logic [AW-1:0] tgt);
        logic [59:0] d;
        d = rand60();
        d[59:56]   = op;
        d[AW-1:0]  = tgt;
        return d;
    endfunction

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        branch_en  = 1'b0;
        jump_en    = 1'b0;
        alu_zero   = 1'b0;
        step();
        step();
        exp_pc    = RPC;
        exp_addr  = '0;
        exp_instr = '0;
        exp_err   = 1'b0;
        phase     = P_FETCH;
        chk_en    = 1;
        check("rst_pc",    64'(pc),        64'h0);
        check("rst_instr", 64'(instr),     64'h0);
        check("rst_req",   64'(imem_req),  64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        rst = 1'b0;

        // Sequential fetch: addresses 0,1,2,3, decode every 4 cycles.
        req_log.delete();
        dec_cyc.delete();
        for (int k = 0; k < 4; k++) run_instr(mk(4'b0001, AW'(k + 9)), 0, 0, 0, 1, 0);
        check("seq_req_count", 64'(req_log.size()), 64'd4);
        if (req_log.size() == 4) begin
            for (int k = 0; k < 4; k++) check("seq_addr", 64'(req_log[k]), 64'(k));
        end
        check("seq_dec_count", 64'(dec_cyc.size()), 64'd4);
        if (dec_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++) check("dec_spacing", 64'(dec_cyc[k] - dec_cyc[k-1]), 64'd4);
        end
        check("seq_pc", 64'(pc), 64'h4);

        run_instr(mk(4'b0001, 8'h33), 0, 0, 1, 0, 0);
        check("pc_before_jump", 64'(pc), 64'h5);
        run_instr(mk(4'b1111, 8'h40), 0, 1, 0, 0, 0);
        check("jump_pc", 64'(pc), 64'h40);
        run_instr(mk(4'b0010, 8'h10), 1, 0, 1, 2, 0);
        check("jump_req_addr", 64'(req_log[$]), 64'h40);
        check("branch_taken", 64'(pc), 64'h10);
        run_instr(mk(4'b0010, 8'h77), 1, 0, 0, 0, 0);
        check("branch_not_taken", 64'(pc), 64'h11);
        run_instr(mk(4'b0011, 8'h22), 1, 1, 0, 0, 0);
        check("jump_over_branch", 64'(pc), 64'h22);
        run_instr(mk(4'b1111, 8'hFF), 0, 1, 1, 0, 0);
        run_instr(mk(4'b0001, 8'h5A), 0, 0, 0, 0, 0);
        check("wrap_req_addr", 64'(req_log[$]), 64'hFF);
        check("wrap_pc", 64'(pc), 64'h0);

        // Stall for 5 fetch cycles: no extra request, pc unchanged meanwhile.
        begin
            int n0;
            n0 = req_log.size();
            run_instr(mk(4'b0001, 8'h66), 0, 0, 0, 0, 5);
            check("stall_req_count", 64'(req_log.size() - n0), 64'd1);
            check("stall_pc", 64'(pc), 64'h1);
        end

        // Reset while waiting; the late response must be dropped.
        stall      = 1'b0;
        imem_valid = 1'b0;
        step();
        phase    = P_REQ;
        exp_addr = exp_pc;
        step();
        phase      = P_WAIT;
        rst        = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = mk(4'b1010, 8'h99);
        step();
        exp_pc    = RPC;
        exp_addr  = '0;
        exp_instr = '0;
        exp_err   = 1'b0;
        phase     = P_FETCH;
        rst       = 1'b0;
        stall     = 1'b1;
        step();
        check("rst_mid_instr", 64'(instr), 64'h0);
        run_instr(mk(4'b0100, 8'h12), 0, 0, 0, 1, 1);
        check("rst_mid_req_addr", 64'(req_log[$]), 64'(RPC));

`ifdef IFU_TIMEOUT_EN
        // Response on the last allowed wait cycle: captured, no error.
        run_instr(mk(4'b0101, 8'h00), 0, 0, 0, TMO - 1, 0);
        check("timeout_edge_err", 64'(fetch_err), 64'h0);
        // No response at all: error and reissue of the same address.
        begin
            int n0;
            stall      = 1'b0;
            imem_valid = 1'b0;
            step();
            phase    = P_REQ;
            exp_addr = exp_pc;
            for (int i = 0; i < TMO - 1; i++) begin
                step();
                phase = P_WAIT;
            end
            n0 = req_log.size();
            step();
            phase   = P_FETCH;
            exp_err = 1'b1;
            run_instr(mk(4'b0001, 8'h00), 0, 0, 0, 0, 0);
            check("timeout_reissue_count", 64'(req_log.size() - n0), 64'd1);
            check("timeout_reissue_addr", 64'(req_log[$]), 64'(req_log[n0-1]));
            check("timeout_err", 64'(fetch_err), 64'h1);
        end
`endif

        // Randomized instruction stream.
        for (int k = 0; k < 150; k++) begin
            run_instr(rand60(), ($urandom % 3) == 0, ($urandom % 4) == 0, 1'($urandom % 2),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
